// File: rtl/uart_cmd_parser.sv
// UART byte stream -> SD command frame assembler (SYNC, CMD, ARG x4, SUM) with valid/ready output.
// Define UART_CMD_CRC7_EN to compute cmd_crc7 serially before presenting the command.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 520800,
  parameter int         TO_W           = 20
) (
  input  logic        ex_clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc7,
  output logic        err_checksum,
  output logic        err_frame,
  output logic        err_timeout,
  output logic        busy
);

`ifdef UART_CMD_CRC7_EN
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_SUM, S_CRC, S_OUT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_SUM, S_OUT} state_t;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [5:0]        idx_q, idx_d, oidx_q, oidx_d;
  logic [31:0]       arg_q, arg_d, oarg_q, oarg_d;
  logic [7:0]        sum_q, sum_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ack_q;
  logic              errc_q, errc_d, errf_q, errf_d, errt_q, errt_d;
  logic              accepting, take;
`ifdef UART_CMD_CRC7_EN
  logic [6:0]        crc_q, crc_d;
  logic [39:0]       crc_sh_q, crc_sh_d;
  logic [5:0]        crc_cnt_q, crc_cnt_d;
  logic              crc_fb;
`endif

  // The cycle after an ack the upstream register still shows the old byte, so it is skipped.
  assign accepting = (state_q == S_IDLE) || (state_q == S_CMD) ||
                     (state_q == S_ARG)  || (state_q == S_SUM);
  assign take      = reset && rx_valid && accepting && !ack_q;

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    oidx_d  = oidx_q;
    oarg_d  = oarg_q;
    errc_d  = 1'b0;
    errf_d  = 1'b0;
    errt_d  = 1'b0;
`ifdef UART_CMD_CRC7_EN
    crc_d     = crc_q;
    crc_sh_d  = crc_sh_q;
    crc_cnt_d = crc_cnt_q;
    crc_fb    = crc_sh_q[39] ^ crc_q[6];
`endif
    unique case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (take && rx_data == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD, S_ARG, S_SUM: begin
        if (take) begin
          to_d = '0;
          if (state_q == S_CMD) begin
            if (rx_data[7:6] != 2'b01) begin
              errf_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d   = rx_data[5:0];
              sum_d   = rx_data;
              cnt_d   = 2'd0;
              state_d = S_ARG;
            end
          end else if (state_q == S_ARG) begin
            arg_d = {arg_q[23:0], rx_data};
            sum_d = sum_q ^ rx_data;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_SUM;
          end else if (rx_data == sum_q) begin
            oidx_d = idx_q;
            oarg_d = arg_q;
`ifdef UART_CMD_CRC7_EN
            crc_d     = 7'd0;
            crc_sh_d  = {2'b01, idx_q, arg_q};
            crc_cnt_d = 6'd0;
            state_d   = S_CRC;
`else
            state_d = S_OUT;
`endif
          end else begin
            errc_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          errt_d  = 1'b1;
          to_d    = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
`ifdef UART_CMD_CRC7_EN
      S_CRC: begin
        to_d      = '0;
        crc_d     = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        crc_sh_d  = {crc_sh_q[38:0], 1'b0};
        crc_cnt_d = crc_cnt_q + 6'd1;
        if (crc_cnt_q == 6'd39) state_d = S_OUT;
      end
`endif
      S_OUT: begin
        to_d = '0;
        if (cmd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ex_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      to_q    <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      oidx_q  <= '0;
      oarg_q  <= '0;
      ack_q   <= 1'b0;
      errc_q  <= 1'b0;
      errf_q  <= 1'b0;
      errt_q  <= 1'b0;
`ifdef UART_CMD_CRC7_EN
      crc_q     <= '0;
      crc_sh_q  <= '0;
      crc_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      oidx_q  <= oidx_d;
      oarg_q  <= oarg_d;
      ack_q   <= take;
      errc_q  <= errc_d;
      errf_q  <= errf_d;
      errt_q  <= errt_d;
`ifdef UART_CMD_CRC7_EN
      crc_q     <= crc_d;
      crc_sh_q  <= crc_sh_d;
      crc_cnt_q <= crc_cnt_d;
`endif
    end
  end

  assign rx_ack       = take;
  assign cmd_valid    = (state_q == S_OUT);
  assign cmd_index    = oidx_q;
  assign cmd_arg      = oarg_q;
`ifdef UART_CMD_CRC7_EN
  assign cmd_crc7     = crc_q;
`else
  assign cmd_crc7     = 7'd0;
`endif
  assign err_checksum = errc_q;
  assign err_frame    = errf_q;
  assign err_timeout  = errt_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames, backpressure, errors, junk, timeout, mid-frame reset.
module tb_uart_cmd_parser;
  localparam int TO = 50;

  logic        ex_clk = 1'b0, reset = 1'b0, rx_valid = 1'b0, cmd_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ack, cmd_valid, err_checksum, err_frame, err_timeout, busy;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc7;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .ex_clk(ex_clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ack(rx_ack), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc7(cmd_crc7),
    .err_checksum(err_checksum), .err_frame(err_frame), .err_timeout(err_timeout),
    .busy(busy));

  always #5 ex_clk = ~ex_clk;

  int pass = 0, total = 0;
  int cyc = 0, n_ack = 0, n_valid = 0, n_cmd = 0, n_ec = 0, n_ef = 0, n_et = 0, viol = 0;
  int last_ack_cyc = 0, last_hs_cyc = 0;
  logic [5:0]  last_idx;
  logic [31:0] last_arg;
  logic [6:0]  last_crc;
  logic        prev_valid = 1'b0;

  // Observer sampled mid-cycle, away from the active edge.
  always @(negedge ex_clk) begin
    cyc++;
    if (rx_ack) begin n_ack++; last_ack_cyc = cyc; end
    if (cmd_valid) n_valid++;
    if (cmd_valid && cmd_ready) begin
      n_cmd++; last_hs_cyc = cyc;
      last_idx = cmd_index; last_arg = cmd_arg; last_crc = cmd_crc7;
    end
    n_ec += int'(err_checksum);
    n_ef += int'(err_frame);
    n_et += int'(err_timeout);
    if ((int'(err_checksum) + int'(err_frame) + int'(err_timeout)) > 1) viol++;
    if ((err_checksum || err_frame || err_timeout) && cmd_valid && !prev_valid) viol++;
    prev_valid = cmd_valid;
  end

  task clear_counts();
    n_ack = 0; n_valid = 0; n_cmd = 0; n_ec = 0; n_ef = 0; n_et = 0;
  endtask

  task send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ex_clk);
      if (rx_ack) begin
        @(posedge ex_clk); #1; rx_valid = 1'b0;
        return;
      end
    end
    total++;
    $display("FAIL byte_ack: byte %h got no rx_ack within 200 cycles", b);
    rx_valid = 1'b0;
  endtask

  task send_frame(input logic [55:0] f);
    for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task idle(input int n);
    repeat (n) @(negedge ex_clk);
    @(posedge ex_clk); #1;
  endtask

  task test_reset();
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (3) @(negedge ex_clk);
    total++;
    if ({rx_ack, cmd_valid, cmd_index, cmd_arg, cmd_crc7, err_checksum, err_frame, err_timeout, busy} !== '0)
      $display("FAIL reset_outputs: ack=%b valid=%b idx=%h arg=%h crc=%h errs=%b%b%b busy=%b, want all 0",
               rx_ack, cmd_valid, cmd_index, cmd_arg, cmd_crc7, err_checksum, err_frame, err_timeout, busy);
    else pass++;
    rx_valid = 1'b0;
    @(posedge ex_clk); #1; reset = 1'b1;
    idle(2);
    total++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, cmd_valid);
    else pass++;
  endtask

  task test_basic();
    clear_counts(); cmd_ready = 1'b1;
    send_frame(56'hA5_40_00_00_00_00_40);
`ifndef UART_CMD_CRC7_EN
    total++;
    if (cmd_valid !== 1'b1) $display("FAIL basic_latency: cmd_valid=%b right after SUM take, want 1", cmd_valid);
    else pass++;
`endif
    idle(60);
    total++;
    if (n_ack != 7 || n_valid != 1 || n_cmd != 1)
      $display("FAIL basic_counts: acks=%0d valid_cycles=%0d cmds=%0d, want 7 1 1", n_ack, n_valid, n_cmd);
    else pass++;
    total++;
    if (last_idx !== 6'd0 || last_arg !== 32'h0) $display("FAIL basic_cmd: idx=%0d arg=%h, want 0 0", last_idx, last_arg);
    else pass++;
`ifdef UART_CMD_CRC7_EN
    total++;
    if (last_crc !== 7'h4A) $display("FAIL basic_crc7: crc=%h, want 4a", last_crc);
    else pass++;
`endif
    total++;
    if (n_ec + n_ef + n_et != 0) $display("FAIL basic_noerr: errors=%0d, want 0", n_ec + n_ef + n_et);
    else pass++;
  endtask

  task test_backpressure();
    int acks0; logic hold_ok; logic got;
    clear_counts(); cmd_ready = 1'b0;
    send_frame(56'hA5_51_00_00_02_00_53);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge ex_clk); got = cmd_valid; end
    total++;
    if (!got) $display("FAIL bp_valid: cmd_valid=0 after 100 cycles, want 1");
    else pass++;
    @(posedge ex_clk); #1;
    rx_data = 8'hA5; rx_valid = 1'b1; acks0 = n_ack; hold_ok = 1'b1;
    repeat (20) begin
      @(negedge ex_clk);
      if (cmd_valid !== 1'b1 || cmd_index !== 6'd17 || cmd_arg !== 32'h200) hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) $display("FAIL bp_hold: valid=%b idx=%0d arg=%h, want 1 17 00000200", cmd_valid, cmd_index, cmd_arg);
    else pass++;
    total++;
    if (n_ack != acks0) $display("FAIL bp_no_ack: acks during backpressure=%0d, want 0", n_ack - acks0);
    else pass++;
    @(posedge ex_clk); #1; cmd_ready = 1'b1;
    for (int i = 0; i < 10 && n_ack == acks0; i++) @(negedge ex_clk);
    @(posedge ex_clk); #1; rx_valid = 1'b0;
    total++;
    if (n_ack != acks0 + 1 || last_ack_cyc != last_hs_cyc + 1)
      $display("FAIL bp_queued_ack: acks=%0d ack_cyc=%0d hs_cyc=%0d, want 1 ack one cycle after handshake",
               n_ack - acks0, last_ack_cyc, last_hs_cyc);
    else pass++;
    total++;
    if (n_cmd != 1 || last_idx !== 6'd17 || last_arg !== 32'h200)
      $display("FAIL bp_cmd: cmds=%0d idx=%0d arg=%h, want 1 17 00000200", n_cmd, last_idx, last_arg);
    else pass++;
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    idle(60);
    total++;
    if (n_cmd != 2 || last_idx !== 6'd0 || last_arg !== 32'h0)
      $display("FAIL bp_followup: cmds=%0d idx=%0d arg=%h, want 2 0 0", n_cmd, last_idx, last_arg);
    else pass++;
  endtask

  task test_errors();
    clear_counts(); cmd_ready = 1'b1;
    send_frame(56'hA5_48_00_00_00_00_00);
    idle(5);
    total++;
    if (n_ec != 1 || n_ef != 0 || n_et != 0 || n_valid != 0 || busy !== 1'b0)
      $display("FAIL err_sum: cks=%0d frm=%0d to=%0d valid=%0d busy=%b, want 1 0 0 0 0", n_ec, n_ef, n_et, n_valid, busy);
    else pass++;
    total++;
    if (cmd_index !== 6'd0 || cmd_arg !== 32'h0)
      $display("FAIL err_sum_hold: idx=%0d arg=%h, want 0 0 (unchanged)", cmd_index, cmd_arg);
    else pass++;
    clear_counts();
    send_byte(8'hA5); send_byte(8'hC8);
    idle(5);
    total++;
    if (n_ef != 1 || n_ec != 0 || n_et != 0 || n_valid != 0 || busy !== 1'b0)
      $display("FAIL err_frame: frm=%0d cks=%0d to=%0d valid=%0d busy=%b, want 1 0 0 0 0", n_ef, n_ec, n_et, n_valid, busy);
    else pass++;
    clear_counts();
    send_frame(56'hA5_48_00_00_00_01_49);
    idle(60);
    total++;
    if (n_cmd != 1 || last_idx !== 6'd8 || last_arg !== 32'h1)
      $display("FAIL err_recover: cmds=%0d idx=%0d arg=%h, want 1 8 00000001", n_cmd, last_idx, last_arg);
    else pass++;
  endtask

  task test_junk();
    clear_counts(); cmd_ready = 1'b1;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    total++;
    if (n_ack != 3 || busy !== 1'b0) $display("FAIL junk_drop: acks=%0d busy=%b, want 3 0", n_ack, busy);
    else pass++;
    send_frame(56'hA5_4C_12_34_56_78_44);
    idle(60);
    total++;
    if (n_ack != 10 || n_cmd != 1 || last_idx !== 6'd12 || last_arg !== 32'h12345678)
      $display("FAIL junk_frame: acks=%0d cmds=%0d idx=%0d arg=%h, want 10 1 12 12345678", n_ack, n_cmd, last_idx, last_arg);
    else pass++;
  endtask

  task test_timeout();
    clear_counts(); cmd_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    repeat (TO) @(negedge ex_clk);
    total++;
    if (n_et != 0 || busy !== 1'b1) $display("FAIL to_early: to=%0d busy=%b before limit, want 0 1", n_et, busy);
    else pass++;
    repeat (30) @(negedge ex_clk);
    total++;
    if (n_et != 1 || n_ec != 0 || n_ef != 0 || busy !== 1'b0)
      $display("FAIL to_fire: to=%0d cks=%0d frm=%0d busy=%b, want 1 0 0 0", n_et, n_ec, n_ef, busy);
    else pass++;
    @(posedge ex_clk); #1;
    send_frame(56'hA5_51_00_00_02_00_53);
    idle(60);
    total++;
    if (n_cmd != 1 || last_idx !== 6'd17 || last_arg !== 32'h200)
      $display("FAIL to_recover: cmds=%0d idx=%0d arg=%h, want 1 17 00000200", n_cmd, last_idx, last_arg);
    else pass++;
  endtask

  task test_reset_midframe();
    clear_counts(); cmd_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h44); send_byte(8'h00);
    rx_data = 8'h11; rx_valid = 1'b1; reset = 1'b0;
    @(negedge ex_clk);
    total++;
    if ({rx_ack, cmd_valid, cmd_index, cmd_arg, cmd_crc7, err_checksum, err_frame, err_timeout, busy} !== '0)
      $display("FAIL midreset_outputs: ack=%b valid=%b idx=%h arg=%h busy=%b, want all 0",
               rx_ack, cmd_valid, cmd_index, cmd_arg, busy);
    else pass++;
    rx_valid = 1'b0;
    @(posedge ex_clk); #1; reset = 1'b1;
    clear_counts();
    send_frame(56'hA5_4C_12_34_56_78_44);
    idle(60);
    total++;
    if (n_cmd != 1 || last_idx !== 6'd12 || last_arg !== 32'h12345678 || n_ec + n_ef + n_et != 0)
      $display("FAIL midreset_frame: cmds=%0d idx=%0d arg=%h errs=%0d, want 1 12 12345678 0",
               n_cmd, last_idx, last_arg, n_ec + n_ef + n_et);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_junk();
    test_timeout();
    test_reset_midframe();
    total++;
    if (viol != 0) $display("FAIL err_exclusive: violations=%0d, want 0", viol);
    else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
